// File: rtl/dmem_responder.sv
// Single-outstanding RV32 data-memory responder: byte-addressed loads/stores
// against internal word storage, response after a fixed LATENCY.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        ready_reg;
  logic        rsp_valid_reg;
  logic        rsp_err_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  funct3_reg;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word_reg;

  logic          accept;
  logic          commit;
  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [2:0]    c_funct3;
  logic          c_misalign;
  logic          c_range;
  logic          c_bad_f3;
  logic          c_err;
  logic [AW-1:0] c_idx;
  logic [3:0]    c_be;
  logic [31:0]   c_wlane;
  logic          wr_en;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  assign accept = req_valid & ready_reg;
  // The commit edge is the one that enters RESP; both reads and writes happen there.
  assign commit = (state_next == RESP) && (state_reg != RESP);

  // With LATENCY=1 the commit coincides with the accept edge, so the live
  // request fields are used; otherwise the latched copy is.
  generate
    if (LATENCY == 1) begin : g_direct
      assign c_we     = req_we;
      assign c_addr   = req_addr;
      assign c_wdata  = req_wdata;
      assign c_funct3 = req_funct3;
    end else begin : g_latched
      assign c_we     = we_reg;
      assign c_addr   = addr_reg;
      assign c_wdata  = wdata_reg;
      assign c_funct3 = funct3_reg;
    end
  endgenerate

  assign c_misalign = ((c_funct3[1:0] == 2'b01) && c_addr[0]) ||
                      ((c_funct3[1:0] == 2'b10) && (c_addr[1:0] != 2'b00));
  assign c_range    = |c_addr[31:AW+2];
  assign c_bad_f3   = c_we ? (c_funct3 >= 3'b011)
                           : ((c_funct3 == 3'b011) || (c_funct3 == 3'b110) || (c_funct3 == 3'b111));
  assign c_err      = c_misalign | c_range | c_bad_f3;
  assign c_idx      = c_addr[AW+1:2];
  assign wr_en      = commit & c_we & ~c_err;

  always_comb begin
    c_be = 4'b0000;
    case (c_funct3[1:0])
      2'b00:   c_be = 4'b0001 << c_addr[1:0];
      2'b01:   c_be = c_addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   c_be = 4'b1111;
      default: c_be = 4'b0000;
    endcase
  end

  // Replicate store data across lanes so each byte enable picks the right source.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign c_wlane[gi*8 +: 8] =
        (c_funct3[1:0] == 2'b00) ? c_wdata[7:0] :
        (c_funct3[1:0] == 2'b01) ? c_wdata[(gi % 2)*8 +: 8] :
                                   c_wdata[gi*8 +: 8];
    end
  endgenerate

  // Storage has no reset so contents survive reset assertion.
  always_ff @(posedge clk) begin
    if (commit) begin
      rd_word_reg <= mem[c_idx];
    end
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b]) begin
          mem[c_idx][b*8 +: 8] <= c_wlane[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_next = 4'(cnt_reg - 4'd1);
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_reg && rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      funct3_reg    <= 3'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ready_reg     <= (state_next == IDLE);
      rsp_valid_reg <= (state_next == RESP);
      if (commit) begin
        rsp_err_reg <= c_err;
      end else if (state_next != RESP) begin
        rsp_err_reg <= 1'b0;
      end
      if (accept) begin
        we_reg     <= req_we;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
        funct3_reg <= req_funct3;
      end
    end
  end

  always_comb begin
    ld_byte = rd_word_reg[7:0];
    case (addr_reg[1:0])
      2'b00:   ld_byte = rd_word_reg[7:0];
      2'b01:   ld_byte = rd_word_reg[15:8];
      2'b10:   ld_byte = rd_word_reg[23:16];
      default: ld_byte = rd_word_reg[31:24];
    endcase
    ld_half = addr_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
    ld_ext  = 32'd0;
    case (funct3_reg)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = rd_word_reg;
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = 32'd0;
    endcase
  end

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = (rsp_valid_reg && !rsp_err_reg && !we_reg) ? ld_ext : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table through a scoreboard queue, then
// back-pressure and reset-during-store sequences.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   txn_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request and return at the negedge after the accept edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3);
    int w;
    req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 20 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs to show the request was latched.
    req_valid  = 1'b0;
    req_we     = ~we;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
  endtask

  // Wait for a response, compare it with the queue head, complete the handshake.
  task automatic get_rsp(input logic we, input logic [31:0] addr, input logic [2:0] f3);
    int   lat;
    exp_t e;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    if (sbq.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: got response expected none");
    end else begin
      e = sbq.pop_front();
      check("rdata", rsp_rdata, e.rdata);
      check("err", 32'(rsp_err), 32'(e.err));
    end
    $display("txn %0d we=%0d addr=%h f3=%0d rdata=%h err=%0d lat=%0d",
             txn_no, we, addr, f3, rsp_rdata, rsp_err, lat);
    txn_no++;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input vec_t v);
    exp_t e;
    send(v.we, v.addr, v.wdata, v.f3);
    e.rdata = v.rdata;
    e.err   = v.err;
    sbq.push_back(e);
    get_rsp(v.we, v.addr, v.f3);
  endtask

  vec_t vecs[27];

  initial begin
    vec_t v;
    exp_t e;
    int   w;
    logic [31:0] top_addr;
    top_addr = 32'(4 * DEPTH);

    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h13,   32'h0,        3'b000, 32'hFFFFFFDE, 1'b0};
    vecs[3]  = '{1'b0, 32'h13,   32'h0,        3'b100, 32'h000000DE, 1'b0};
    vecs[4]  = '{1'b0, 32'h12,   32'h0,        3'b001, 32'hFFFFDEAD, 1'b0};
    vecs[5]  = '{1'b0, 32'h10,   32'h0,        3'b101, 32'h0000BEEF, 1'b0};
    vecs[6]  = '{1'b0, 32'h10,   32'h0,        3'b000, 32'hFFFFFFEF, 1'b0};
    vecs[7]  = '{1'b1, 32'h11,   32'hFFFFFF12, 3'b000, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEAD12EF, 1'b0};
    vecs[9]  = '{1'b0, 32'h11,   32'h0,        3'b100, 32'h00000012, 1'b0};
    vecs[10] = '{1'b0, 32'h11,   32'h0,        3'b010, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 32'h13,   32'h0000FFFF, 3'b001, 32'h0,        1'b1};
    vecs[12] = '{1'b0, top_addr, 32'h0,        3'b010, 32'h0,        1'b1};
    vecs[13] = '{1'b1, top_addr, 32'h11111111, 3'b010, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1};
    vecs[15] = '{1'b1, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1};
    vecs[16] = '{1'b1, 32'h10,   32'h0,        3'b100, 32'h0,        1'b1};
    vecs[17] = '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEAD12EF, 1'b0};
    vecs[18] = '{1'b1, 32'h12,   32'hABCD1234, 3'b001, 32'h0,        1'b0};
    vecs[19] = '{1'b0, 32'h10,   32'h0,        3'b010, 32'h123412EF, 1'b0};
    vecs[20] = '{1'b0, 32'h10,   32'h0,        3'b001, 32'h000012EF, 1'b0};
    vecs[21] = '{1'b1, 32'hFFC,  32'h80000001, 3'b010, 32'h0,        1'b0};
    vecs[22] = '{1'b0, 32'hFFE,  32'h0,        3'b001, 32'hFFFF8000, 1'b0};
    vecs[23] = '{1'b1, 32'h20,   32'h5555AAAA, 3'b010, 32'h0,        1'b0};
    vecs[24] = '{1'b0, 32'h20,   32'h0,        3'b010, 32'h5555AAAA, 1'b0};
    vecs[25] = '{1'b0, 32'h10,   32'h0,        3'b110, 32'h0,        1'b1};
    vecs[26] = '{1'b0, 32'h10,   32'h0,        3'b111, 32'h0,        1'b1};

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_funct3 = 3'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) txn(vecs[i]);

    // Back-pressure: response held 5 cycles while a competing request is ignored.
    send(1'b0, 32'h10, 32'h0, 3'b010);
    e.rdata = 32'h123412EF; e.err = 1'b0;
    sbq.push_back(e);
    w = 1;
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("bp_latency", 32'(w), 32'(LAT));
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'b010; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'h123412EF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      $display("txn %0d stall cycle %0d rsp_valid=%0d rdata=%h req_ready=%0d",
               txn_no, k, rsp_valid, rsp_rdata, req_ready);
      @(negedge clk);
    end
    req_valid = 1'b0;
    e = sbq.pop_front();
    check("bp_rdata", rsp_rdata, e.rdata);
    check("bp_err", 32'(rsp_err), 32'(e.err));
    txn_no++;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_ready_after_hs", 32'(req_ready), 32'd1);
    check("bp_valid_after_hs", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("bp_no_spurious_rsp", 32'(rsp_valid), 32'd0);
    v = '{1'b0, 32'h10, 32'h0, 3'b010, 32'h123412EF, 1'b0};
    txn(v);

    // Reset while a store is in flight: outputs clear and memory is untouched.
    send(1'b1, 32'h20, 32'h1, 3'b010);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    $display("txn %0d store 0x20 dropped by reset", txn_no);
    txn_no++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 32'(req_ready), 32'd1);
    check("rst_release_valid", 32'(rsp_valid), 32'd0);
    v = '{1'b0, 32'h20, 32'h0, 3'b010, 32'h5555AAAA, 1'b0};
    txn(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words of internal storage (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response valid (legal 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous assert, active-low, synchronous deassert by the system.
REQ-005 SHALL have port req_valid  input  1  initiator presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, LSB-aligned (rs2 value).
REQ-010 SHALL have port req_funct3  input  3  RV32 load/store funct3 (size and signedness).
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator takes the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data, extended per funct3; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned, out of range, or had an illegal funct3.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; exactly one outstanding request.
REQ-016 SHALL drive req_ready=1 only in IDLE; accept = req_valid & req_ready at a rising edge.
REQ-017 SHALL latch we, addr, wdata and funct3 on accept; later input changes have no effect.
REQ-018 SHALL go IDLE->WAIT on accept with a counter loaded to LATENCY-1; if LATENCY=1, SHALL go directly IDLE->RESP.
REQ-019 SHALL decrement the counter in WAIT and go WAIT->RESP when it reaches 0; response valid exactly LATENCY cycles after the accept edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid & rsp_ready, then go to IDLE; req_ready rises the cycle after the handshake (no same-cycle re-accept).
REQ-021 Loads: 000 LB sign-extend byte addr[1:0]; 001 LH sign-extend half addr[1]; 010 LW word; 100 LBU and 101 LHU zero-extend.
REQ-022 Stores: 000 SB writes byte lane addr[1:0] from wdata[7:0]; 001 SH writes half lane addr[1] from wdata[15:0]; 010 SW writes all lanes; other bytes unchanged.
REQ-023 SHALL set rsp_err and suppress any write when: half access with addr[0]=1; word access with addr[1:0]!=0; word index addr>>2 >= DEPTH_WORDS; load funct3 in {011,110,111}; store funct3 >= 011.
REQ-024 SHALL perform the store write on the edge entering RESP, not earlier; a load SHALL read memory on that same edge.
REQ-025 SHALL ignore req_valid while not in IDLE; no queuing.
REQ-026 SHALL return rsp_rdata=0 for every store response and every error response.

Reset
REQ-027 SHALL, while rst=0, force state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; after rst=1, req_ready=1 in IDLE.
REQ-028 SHALL drop an in-flight request on reset assertion; a store not yet committed per REQ-024 SHALL NOT modify memory.
REQ-029 SHALL NOT clear memory contents on reset.

Verification
REQ-030 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid exactly 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-031 After REQ-030: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-032 SB 0x11 data 0x12, then LW 0x10 -> 0xDEAD12EF.
REQ-033 LW 0x11, SH 0x13, and LW at byte address 4*DEPTH_WORDS -> err=1, rdata=0; memory word 0x10 unchanged.
REQ-034 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, new req_valid ignored; accepted only after the handshake.
REQ-035 SW 0x20 data 0x1 accepted, rst asserted 1 cycle later (before RESP) -> outputs cleared immediately; after release, LW 0x20 returns the old value.
